// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: op/error encodings, FSM states and
// the memory geometry that must agree with data_memory_with_stack.
package mem_pkg;

  localparam int DATA_MEM_SIZE = 256;
  localparam int STACK_START   = 200;
  localparam int STACK_DEPTH   = 14;
  localparam int DEPTH_W       = 4;

  typedef enum logic [1:0] {
    OP_LW   = 2'b00,
    OP_SW   = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_RANGE = 2'b10,
    ERR_STACK = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic isReadOp(input op_e op);
    return (op == OP_LW) || (op == OP_POP);
  endfunction

  function automatic logic isStaticOp(input op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stack_tracker.sv
// Shadow copy of the data memory's stack pointer, kept as a push/pop depth so
// the sequencer can reject overflow and underflow before touching memory.
module mem_stack_tracker
  import mem_pkg::*;
#(
  parameter int STACK_DEPTH_P = STACK_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [DEPTH_W-1:0] depth_q, depth_d;

  assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH_P));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;

  // Validation already blocks illegal ops; the guards just keep the count from wrapping.
  always_comb begin
    depth_d = depth_q;
    if (inc_i && !full_o) begin
      depth_d = depth_q + 1'b1;
    end else if (dec_i && !empty_o) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: validates one LW/SW/PUSH/POP, strobes the data memory
// for a single cycle and returns read data or an error code to write-back.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int STACK_START_P = STACK_START,
  parameter int STACK_DEPTH_P = STACK_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [31:0]        addr_in,
  input  logic [31:0]        wdata_in,
  output logic               ready,
  output logic               mem_write,
  output logic               mem_read,
  output logic               dataMemEnable,
  output logic [31:0]        address,
  output logic [31:0]        data_in,
  input  logic [31:0]        data_out,
  output logic               done,
  output logic               rd_valid,
  output logic [31:0]        rd_data,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [DEPTH_W-1:0] stack_depth
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  err_e        errCode_q, errCode_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdData_q, rdData_d;

  op_e  reqOp;
  err_e reqErr;
  logic stackInc, stackDec, stackFull, stackEmpty;

  mem_stack_tracker #(
    .STACK_DEPTH_P(STACK_DEPTH_P)
  ) u_stack_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (stackInc),
    .dec_i  (stackDec),
    .depth_o(stack_depth),
    .full_o (stackFull),
    .empty_o(stackEmpty)
  );

  assign reqOp    = op_e'(op);
  assign rd_data  = rdData_q;
  assign err_code = errCode_q;

  // Catch accesses the memory would silently drop, before any strobe is issued.
  always_comb begin
    reqErr = ERR_NONE;
    unique case (reqOp)
      OP_LW, OP_SW: begin
        if (addr_in[1:0] != 2'b00) begin
          reqErr = ERR_ALIGN;
        end else if (addr_in[31:2] >= 30'(STACK_START_P)) begin
          reqErr = ERR_RANGE;
        end
      end
      OP_PUSH: if (stackFull) reqErr = ERR_STACK;
      OP_POP:  if (stackEmpty) reqErr = ERR_STACK;
      default: reqErr = ERR_NONE;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    errCode_d     = errCode_q;
    rdData_d      = rdData_q;
    ready         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    dataMemEnable = 1'b0;
    address       = '0;
    data_in       = '0;
    done          = 1'b0;
    rd_valid      = 1'b0;
    err           = 1'b0;
    stackInc      = 1'b0;
    stackDec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          op_d      = reqOp;
          addr_d    = addr_in;
          wdata_d   = wdata_in;
          errCode_d = reqErr;
          state_d   = (reqErr == ERR_NONE) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        dataMemEnable = isStaticOp(op_q);
        mem_read      = isReadOp(op_q);
        mem_write     = !isReadOp(op_q);
        address       = isStaticOp(op_q) ? addr_q : '0;
        data_in       = (op_q == OP_SW || op_q == OP_PUSH) ? wdata_q : '0;
        stackInc      = (op_q == OP_PUSH);
        stackDec      = (op_q == OP_POP);
        state_d       = isReadOp(op_q) ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        rdData_d = data_out;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        err      = (errCode_q != ERR_NONE);
        rd_valid = isReadOp(op_q) && (errCode_q == ERR_NONE);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LW;
      errCode_q <= ERR_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdData_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      errCode_q <= errCode_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdData_q  <= rdData_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural data memory that has a
// registered read port and an internal stack pointer.
module tb_mem_access_ctrl;

  localparam logic [1:0] LW   = 2'b00;
  localparam logic [1:0] SW   = 2'b01;
  localparam logic [1:0] PUSH = 2'b10;
  localparam logic [1:0] POP  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [31:0] data_out = '0;
  logic        ready, mem_write, mem_read, dataMemEnable, done, rd_valid, err;
  logic [31:0] address, data_in, rd_data;
  logic [1:0]  err_code;
  logic [3:0]  stack_depth;

  int compareCount = 0;
  int mismatchCount = 0;

  logic [31:0] memModel [0:255];
  logic [31:0] stackModel [0:31];
  logic [4:0]  tbSp = '0;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .ready        (ready),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .dataMemEnable(dataMemEnable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .done         (done),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .err          (err),
    .err_code     (err_code),
    .stack_depth  (stack_depth)
  );

  always #5 clk = ~clk;

  // Memory contents survive reset; only the stack pointer is reinitialised.
  always @(posedge clk) begin
    if (mem_write && dataMemEnable) memModel[address[9:2]] <= data_in;
    if (mem_read) data_out <= dataMemEnable ? memModel[address[9:2]] : stackModel[tbSp - 5'd1];
    if (!rst_n) begin
      tbSp <= '0;
    end else if (mem_write && !dataMemEnable) begin
      stackModel[tbSp] <= data_in;
      tbSp <= tbSp + 5'd1;
    end else if (mem_read && !dataMemEnable) begin
      tbSp <= tbSp - 5'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] opV, input logic [31:0] addrV, input logic [31:0] wdataV);
    @(negedge clk);
    checkOutput("ready_before_accept", 32'(ready), 32'd1);
    start = 1'b1;
    op = opV;
    addr_in = addrV;
    wdata_in = wdataV;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes one op from the cycle after acceptance until done, bounded to 6 cycles.
  task automatic runOp(input string tag, input logic [1:0] opV, input logic [31:0] addrV,
                       input logic [31:0] wdataV, input int expLat, input int expRd, input int expWr,
                       input logic expEn, input logic [31:0] expAddr, input logic [31:0] expData,
                       input logic [1:0] expCode, input logic [31:0] expRdData, input logic [3:0] expDepth);
    int doneCyc = 0;
    int rdCnt = 0;
    int wrCnt = 0;
    int bothCnt = 0;
    logic en = 1'b0;
    logic [31:0] sAddr = '0;
    logic [31:0] sData = '0;
    logic oErr = 1'b0;
    logic oRdv = 1'b0;
    logic [1:0] oCode = 2'b00;
    logic [31:0] oRd = '0;
    logic [3:0] oDepth = '0;
    logic expErr;
    logic expRdv;
    expErr = (expCode != 2'b00);
    expRdv = ((opV == LW) || (opV == POP)) && !expErr;
    applyStimulus(opV, addrV, wdataV);
    for (int cyc = 1; cyc <= 6 && doneCyc == 0; cyc++) begin
      if (mem_read || mem_write) begin
        en = dataMemEnable;
        sAddr = address;
        sData = data_in;
      end
      rdCnt += int'(mem_read);
      wrCnt += int'(mem_write);
      bothCnt += int'(mem_read && mem_write);
      if (done) begin
        doneCyc = cyc;
        oErr = err;
        oRdv = rd_valid;
        oCode = err_code;
        oRd = rd_data;
        oDepth = stack_depth;
      end else begin
        @(negedge clk);
      end
    end
    checkOutput({tag, "/latency"}, 32'(doneCyc), 32'(expLat));
    checkOutput({tag, "/readStrobes"}, 32'(rdCnt), 32'(expRd));
    checkOutput({tag, "/writeStrobes"}, 32'(wrCnt), 32'(expWr));
    checkOutput({tag, "/bothStrobes"}, 32'(bothCnt), 32'd0);
    checkOutput({tag, "/dataMemEnable"}, 32'(en), 32'(expEn));
    checkOutput({tag, "/address"}, sAddr, expAddr);
    checkOutput({tag, "/data_in"}, sData, expData);
    checkOutput({tag, "/err"}, 32'(oErr), 32'(expErr));
    checkOutput({tag, "/err_code"}, 32'(oCode), 32'(expCode));
    checkOutput({tag, "/rd_valid"}, 32'(oRdv), 32'(expRdv));
    checkOutput({tag, "/rd_data"}, oRd, expRdData);
    checkOutput({tag, "/stack_depth"}, 32'(oDepth), 32'(expDepth));
  endtask

  initial begin
    int doneCnt;
    int doneAt;
    int wrCnt;
    for (int i = 0; i < 256; i++) memModel[i] = 32'h1000 + i;
    memModel[0] = 32'h2;
    for (int i = 0; i < 32; i++) stackModel[i] = '0;

    // Reset held with start asserted: reset must win.
    rst_n = 1'b0;
    start = 1'b1;
    op = PUSH;
    wdata_in = 32'h55;
    repeat (3) @(negedge clk);
    checkOutput("reset/ready", 32'(ready), 32'd1);
    checkOutput("reset/strobes", {29'd0, mem_read, mem_write, dataMemEnable}, 32'd0);
    checkOutput("reset/address", address, 32'd0);
    checkOutput("reset/data_in", data_in, 32'd0);
    checkOutput("reset/done", {29'd0, done, rd_valid, err}, 32'd0);
    checkOutput("reset/err_code", 32'(err_code), 32'd0);
    checkOutput("reset/rd_data", rd_data, 32'd0);
    checkOutput("reset/stack_depth", 32'(stack_depth), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    runOp("lw0", LW, 32'h0, 32'h0, 3, 1, 0, 1'b1, 32'h0, 32'h0, 2'b00, 32'h2, 4'd0);
    runOp("sw10", SW, 32'h10, 32'hCAFE, 2, 0, 1, 1'b1, 32'h10, 32'hCAFE, 2'b00, 32'h2, 4'd0);
    runOp("lw10", LW, 32'h10, 32'h0, 3, 1, 0, 1'b1, 32'h10, 32'h0, 2'b00, 32'hCAFE, 4'd0);
    runOp("push11", PUSH, 32'h40, 32'h11, 2, 0, 1, 1'b0, 32'h0, 32'h11, 2'b00, 32'hCAFE, 4'd1);
    runOp("push22", PUSH, 32'h0, 32'h22, 2, 0, 1, 1'b0, 32'h0, 32'h22, 2'b00, 32'hCAFE, 4'd2);
    runOp("pop1", POP, 32'h0, 32'h99, 3, 1, 0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h22, 4'd1);
    runOp("pop2", POP, 32'h0, 32'h0, 3, 1, 0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h11, 4'd0);
    runOp("popEmpty", POP, 32'h0, 32'h0, 1, 0, 0, 1'b0, 32'h0, 32'h0, 2'b11, 32'h11, 4'd0);

    for (int i = 0; i < 14; i++) begin
      runOp("pushFill", PUSH, 32'h0, 32'h100 + i, 2, 0, 1, 1'b0, 32'h0, 32'h100 + i, 2'b00, 32'h11, 4'(i + 1));
    end
    runOp("pushFull", PUSH, 32'h0, 32'h777, 1, 0, 0, 1'b0, 32'h0, 32'h0, 2'b11, 32'h11, 4'd14);
    runOp("popTop", POP, 32'h0, 32'h0, 3, 1, 0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h10D, 4'd13);

    runOp("lwMisaligned", LW, 32'h6, 32'h0, 1, 0, 0, 1'b0, 32'h0, 32'h0, 2'b01, 32'h10D, 4'd13);
    runOp("swRange", SW, 32'h320, 32'hDEAD, 1, 0, 0, 1'b0, 32'h0, 32'h0, 2'b10, 32'h10D, 4'd13);
    runOp("lwLastStatic", LW, 32'h31C, 32'h0, 3, 1, 0, 1'b1, 32'h31C, 32'h0, 2'b00, 32'h10C7, 4'd13);

    // start held high through an LW, with op switched to SW after acceptance.
    doneCnt = 0;
    doneAt = 0;
    wrCnt = 0;
    @(negedge clk);
    start = 1'b1;
    op = LW;
    addr_in = 32'h10;
    @(negedge clk);
    op = SW;
    addr_in = 32'h20;
    wdata_in = 32'hBEEF;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      if (done) begin
        doneCnt++;
        doneAt = cyc;
      end
      wrCnt += int'(mem_write);
      if (cyc == 3) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("held/doneCount", 32'(doneCnt), 32'd1);
    checkOutput("held/doneCycle", 32'(doneAt), 32'd3);
    checkOutput("held/writeStrobes", 32'(wrCnt), 32'd0);
    checkOutput("held/rd_data", rd_data, 32'hCAFE);
    checkOutput("held/idleAfter", {30'd0, ready, done}, 32'b10);

    // Reset sampled while the LW sits in WAIT.
    applyStimulus(LW, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midReset/ready", 32'(ready), 32'd1);
    checkOutput("midReset/done", 32'(done), 32'd0);
    checkOutput("midReset/stack_depth", 32'(stack_depth), 32'd0);
    checkOutput("midReset/rd_data", rd_data, 32'd0);
    rst_n = 1'b1;

    runOp("lwAfterReset", LW, 32'h10, 32'h0, 3, 1, 0, 1'b1, 32'h10, 32'h0, 2'b00, 32'hCAFE, 4'd0);
    runOp("popAfterReset", POP, 32'h0, 32'h0, 1, 0, 0, 1'b0, 32'h0, 32'h0, 2'b11, 32'hCAFE, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
